// File: rtl/seg_pkg.sv
// Shared types and width helpers for the multiplexed score-display scanner.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } blink_ph_t;

    typedef logic [3:0] nib_t;

    localparam int unsigned NIB_W = 4;

    // Bits needed to hold the values 0..n-1 (never less than one).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot sequencer: BLANK dead time then SHOW for each digit position in turn.
// Exposes current-slot strobes plus a one-cycle lookahead for registered outputs.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned IDX_W        = idx_w(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             slot_start_c,
    output logic             boundary_c,
    output logic             nxt_show_c,
    output logic             nxt_boundary_c
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = idx_w(CNT_MAX);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // idx only moves on the SHOW->BLANK edge, so idx_d is the SHOW digit whenever nxt_show_c is set.
    always_comb begin
        slot_start_c   = (state_q == BLANK) && (cnt_q == '0);
        boundary_c     = (state_q == SHOW) && (cnt_q == SHOW_LAST) && (idx_q == IDX_LAST);
        nxt_show_c     = (state_d == SHOW);
        nxt_boundary_c = nxt_show_c && (cnt_d == SHOW_LAST) && (idx_d == IDX_LAST);
    end

    assign idx = idx_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for the score display: double-buffered digits,
// leading-zero blanking and per-digit blink, all outputs registered.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [3:0]              dig_nib,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    load_ack,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = idx_w(NUM_DIGITS);
    localparam int unsigned DIG_W = NIB_W * NUM_DIGITS;
    localparam int unsigned BF_W  = idx_w(BLINK_FRAMES);

    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [IDX_W-1:0] idx;
    logic             slot_start_c;
    logic             boundary_c;
    logic             nxt_show_c;
    logic             nxt_boundary_c;

    seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .idx           (idx),
        .slot_start_c  (slot_start_c),
        .boundary_c    (boundary_c),
        .nxt_show_c    (nxt_show_c),
        .nxt_boundary_c(nxt_boundary_c)
    );

    logic [DIG_W-1:0]      active_q, active_d;
    logic [DIG_W-1:0]      staging_q, staging_d;
    logic                  pending_q, pending_d;
    blink_ph_t             blink_ph_q, blink_ph_d;
    logic [BF_W-1:0]       bf_cnt_q, bf_cnt_d;
    logic                  slot_mask_q, slot_mask_d;
    nib_t                  dig_nib_q, dig_nib_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_done_q, frame_done_d;

    nib_t                  cur_nib_c;
    logic                  cur_mask_c;
    logic                  slot_mask_c;
    logic                  seen_nz_c;
    logic [NUM_DIGITS-1:0] lz_mask_c;
    logic [NUM_DIGITS-1:0] mask_vec_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q     <= '0;
            staging_q    <= '0;
            pending_q    <= 1'b0;
            blink_ph_q   <= PH_ON;
            bf_cnt_q     <= '0;
            slot_mask_q  <= 1'b0;
            dig_nib_q    <= '0;
            dig_en_q     <= '0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            active_q     <= active_d;
            staging_q    <= staging_d;
            pending_q    <= pending_d;
            blink_ph_q   <= blink_ph_d;
            bf_cnt_q     <= bf_cnt_d;
            slot_mask_q  <= slot_mask_d;
            dig_nib_q    <= dig_nib_d;
            dig_en_q     <= dig_en_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Digit i (i>0) is a leading zero when it and every digit above it are zero.
    always_comb begin
        seen_nz_c  = 1'b0;
        lz_mask_c  = '0;
        cur_nib_c  = '0;
        cur_mask_c = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            seen_nz_c    = seen_nz_c | (active_q[NIB_W*i +: NIB_W] != '0);
            lz_mask_c[i] = ~seen_nz_c;
        end
        mask_vec_c = (blank_lz ? lz_mask_c : '0)
                   | ((blink_ph_q == PH_OFF) ? blink_en : '0);
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib_c  = active_q[NIB_W*i +: NIB_W];
                cur_mask_c = mask_vec_c[i];
            end
        end
    end

    // Double buffer: staged digits only become visible at a frame boundary.
    always_comb begin
        active_d   = active_q;
        staging_d  = staging_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;
        if (boundary_c) begin
            if (load) begin
                active_d   = digits_in;
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end else if (pending_q) begin
                active_d   = staging_q;
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end
        end else if (load) begin
            staging_d = digits_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        blink_ph_d = blink_ph_q;
        bf_cnt_d   = bf_cnt_q;
        if (boundary_c) begin
            if (bf_cnt_q == BF_LAST) begin
                bf_cnt_d   = '0;
                blink_ph_d = (blink_ph_q == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                bf_cnt_d = bf_cnt_q + BF_W'(1);
            end
        end
    end

    // Mask and nibble are latched at slot start; the lookahead strobes keep outputs cycle-aligned with the timer.
    always_comb begin
        slot_mask_c  = slot_start_c ? cur_mask_c : slot_mask_q;
        slot_mask_d  = slot_mask_c;
        dig_nib_d    = slot_start_c ? cur_nib_c : dig_nib_q;
        frame_done_d = nxt_boundary_c;
        dig_en_d     = '0;
        if (nxt_show_c && !slot_mask_c) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (idx == IDX_W'(i)) begin
                    dig_en_d[i] = 1'b1;
                end
            end
        end
    end

    assign dig_nib    = dig_nib_q;
    assign dig_en     = dig_en_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Frame-table bench for seg_scan_ctrl with a 20-cycle frame (4 digits, 1 dark + 4 lit each).
module tb_seg_scan_ctrl;

    localparam int FRAME = 20;
    localparam int SLOT  = 5;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic        blank_lz;
    logic [3:0]  blink_en;
    logic [3:0]  dig_nib;
    logic [3:0]  dig_en;
    logic        load_ack;
    logic        frame_done;

    int n_cmp;
    int n_err;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (4),
        .BLANK_CYCLES(1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .dig_nib   (dig_nib),
        .dig_en    (dig_en),
        .load_ack  (load_ack),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame of stimulus and the display it must produce.
    typedef struct {
        logic        rst_before;
        logic        blz;
        logic [3:0]  blink;
        logic [3:0]  lit;
        logic [15:0] nibs;
        logic        ack;
        int          ld_a_cyc;
        logic [15:0] ld_a;
        int          ld_b_cyc;
        logic [15:0] ld_b;
    } frame_vec_t;

    frame_vec_t vecs[$];

    function automatic frame_vec_t fv(input logic r, input logic blz, input logic [3:0] blink,
                                      input logic [3:0] lit, input logic [15:0] nibs, input logic ack,
                                      input int ca, input logic [15:0] va,
                                      input int cb, input logic [15:0] vb);
        frame_vec_t v;
        v.rst_before = r;
        v.blz        = blz;
        v.blink      = blink;
        v.lit        = lit;
        v.nibs       = nibs;
        v.ack        = ack;
        v.ld_a_cyc   = ca;
        v.ld_a       = va;
        v.ld_b_cyc   = cb;
        v.ld_b       = vb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Checks and drives ncyc cycles of a frame, starting on its first (dark) cycle.
    task automatic run_frame(input frame_vec_t v, input int fidx, input int ncyc);
        int          slot;
        int          ph;
        logic [3:0]  exp_en;
        logic [15:0] nb;
        for (int c = 0; c < ncyc; c++) begin
            slot   = c / SLOT;
            ph     = c % SLOT;
            nb     = v.nibs;
            exp_en = (ph != 0 && v.lit[slot]) ? 4'(1 << slot) : 4'h0;
            chk($sformatf("f%0d c%0d dig_en", fidx, c), 32'(dig_en), 32'(exp_en));
            if (ph != 0)
                chk($sformatf("f%0d c%0d dig_nib", fidx, c), 32'(dig_nib), 32'(nb[slot*4 +: 4]));
            chk($sformatf("f%0d c%0d frame_done", fidx, c), 32'(frame_done), 32'(c == FRAME - 1));
            chk($sformatf("f%0d c%0d load_ack", fidx, c), 32'(load_ack), 32'(c == 0 && v.ack));
            blank_lz  = v.blz;
            blink_en  = v.blink;
            load      = 1'b0;
            digits_in = 16'h0;
            if (c == v.ld_a_cyc) begin
                load      = 1'b1;
                digits_in = v.ld_a;
            end
            if (c == v.ld_b_cyc) begin
                load      = 1'b1;
                digits_in = v.ld_b;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0;
        blank_lz  = 1'b0;
        blink_en  = 4'h0;

        // Basic load: ack after first boundary, second frame shows 4,3,2,1.
        vecs.push_back(fv(1, 0, 4'h0, 4'hF, 16'h0000, 0,  3, 16'h1234, -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h0, 4'hF, 16'h1234, 1, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h0, 4'hF, 16'h1234, 0, -1, 16'h0,    -1, 16'h0));
        // Leading-zero blanking, including all-zero and an embedded zero.
        vecs.push_back(fv(1, 1, 4'h0, 4'h1, 16'h0000, 0,  2, 16'h0007, -1, 16'h0));
        vecs.push_back(fv(0, 1, 4'h0, 4'h1, 16'h0007, 1, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 1, 4'h0, 4'h1, 16'h0007, 0,  5, 16'h0000, -1, 16'h0));
        vecs.push_back(fv(0, 1, 4'h0, 4'h1, 16'h0000, 1, 10, 16'h0305, -1, 16'h0));
        vecs.push_back(fv(0, 1, 4'h0, 4'h7, 16'h0305, 1, -1, 16'h0,    -1, 16'h0));
        // Two loads in one frame: latest wins, single ack.
        vecs.push_back(fv(1, 0, 4'h0, 4'hF, 16'h0000, 0,  4, 16'hAAAA, 12, 16'h5555));
        vecs.push_back(fv(0, 0, 4'h0, 4'hF, 16'h5555, 1, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h0, 4'hF, 16'h5555, 0, -1, 16'h0,    -1, 16'h0));
        // Load on the boundary cycle goes straight to the display.
        vecs.push_back(fv(1, 0, 4'h0, 4'hF, 16'h0000, 0, 19, 16'h9876, -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h0, 4'hF, 16'h9876, 1, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h0, 4'hF, 16'h9876, 0, -1, 16'h0,    -1, 16'h0));
        // Blink digits 1:0 with a two-frame half period.
        vecs.push_back(fv(1, 0, 4'h3, 4'hF, 16'h0000, 0,  0, 16'h1234, -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h3, 4'hF, 16'h1234, 1, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h3, 4'hC, 16'h1234, 0, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h3, 4'hC, 16'h1234, 0, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h3, 4'hF, 16'h1234, 0, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h3, 4'hF, 16'h1234, 0, -1, 16'h0,    -1, 16'h0));
        vecs.push_back(fv(0, 0, 4'h3, 4'hC, 16'h1234, 0, -1, 16'h0,    -1, 16'h0));

        for (int f = 0; f < vecs.size(); f++) begin
            if (vecs[f].rst_before) do_reset();
            run_frame(vecs[f], f, FRAME);
        end

        // Reset in the middle of digit 2's SHOW with a load still pending.
        blank_lz = 1'b0;
        blink_en = 4'h0;
        do_reset();
        run_frame(fv(0, 0, 4'h0, 4'hF, 16'h0000, 0, 2, 16'h1234, -1, 16'h0), 100, FRAME);
        run_frame(fv(0, 0, 4'h0, 4'hF, 16'h1234, 1, 2, 16'h5555, -1, 16'h0), 101, 12);
        chk("pre-reset dig_en", 32'(dig_en), 32'h4);
        chk("pre-reset dig_nib", 32'(dig_nib), 32'h2);
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset dig_en", 32'(dig_en), 32'h0);
        chk("post-reset dig_nib", 32'(dig_nib), 32'h0);
        chk("post-reset load_ack", 32'(load_ack), 32'h0);
        chk("post-reset frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;
        run_frame(fv(0, 0, 4'h0, 4'hF, 16'h0000, 0, -1, 16'h0, -1, 16'h0), 102, FRAME);
        run_frame(fv(0, 0, 4'h0, 4'hF, 16'h0000, 0, -1, 16'h0, -1, 16'h0), 103, FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
